// File: rtl/cook_timer.sv
// Microwave cook timer: keypad MM:SS entry, countdown while the magnetron runs,
// and a done flag that feeds the magnetron controller reset path.
module cook_timer #(
    parameter int unsigned TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clearn,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       timer_done
);

    localparam int unsigned     PS_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICKS_PER_SEC - 1);
    localparam logic [PS_W-1:0] PS_ONE = PS_W'(1);
    localparam logic [PS_W-1:0] PS_ZERO = PS_W'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_r, state_next_s;
    logic [PS_W-1:0] ps_r, ps_next_s;
    logic [15:0]     time_r, time_next_s;  // {min_tens, min_ones, sec_tens, sec_ones}
    logic            accept_s;
    logic [15:0]     entry_s;
    logic [15:0]     dec_s;

    // Shift one keypad digit into the right end; the leftmost digit falls off.
    function automatic logic [15:0] shift_in(input logic [15:0] t, input logic [3:0] d);
        return {t[11:0], d};
    endfunction

    // Subtract one second with minute borrow; sec_tens may start above 5.
    function automatic logic [15:0] dec_one(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else if (t[7:4] != 4'd0) begin
            r[7:4] = t[7:4] - 4'd1;
            r[3:0] = 4'd9;
        end else if (t[11:8] != 4'd0) begin
            r[11:8] = t[11:8] - 4'd1;
            r[7:0]  = {4'd5, 4'd9};
        end else if (t[15:12] != 4'd0) begin
            r = {t[15:12] - 4'd1, 4'd9, 4'd5, 4'd9};
        end else begin
            r = 16'h0000;
        end
        return r;
    endfunction

    // Digit acceptance and the candidate values for entry and countdown.
    always_comb begin
        accept_s = digit_valid && (digit <= 4'd9) && (state_r != RUN);
        entry_s  = shift_in((state_r == DONE) ? 16'h0000 : time_r, digit);
        dec_s    = dec_one(time_r);
    end

    // Next-state, prescaler and display update; clear overrides everything.
    always_comb begin
        state_next_s = state_r;
        ps_next_s    = ps_r;
        time_next_s  = time_r;
        if (!clearn) begin
            state_next_s = IDLE;
            ps_next_s    = PS_ZERO;
            time_next_s  = 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        time_next_s = entry_s;
                    end else begin
                        time_next_s = time_r;
                    end
                    if (accept_s && (entry_s != 16'h0000)) begin
                        state_next_s = ARMED;
                    end else if (mag_on) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                ARMED: begin
                    if (accept_s) begin
                        time_next_s = entry_s;
                    end else begin
                        time_next_s = time_r;
                    end
                    // Shifting a 0 into X0:00 drops the only nonzero digit.
                    if (accept_s && (entry_s == 16'h0000)) begin
                        state_next_s = IDLE;
                    end else if (mag_on) begin
                        state_next_s = RUN;
                    end else begin
                        state_next_s = ARMED;
                    end
                end
                RUN: begin
                    if (!mag_on) begin
                        state_next_s = (time_r != 16'h0000) ? ARMED : IDLE;
                    end else if (ps_r == PS_MAX) begin
                        ps_next_s    = PS_ZERO;
                        time_next_s  = dec_s;
                        state_next_s = (dec_s == 16'h0000) ? DONE : RUN;
                    end else begin
                        ps_next_s    = ps_r + PS_ONE;
                        state_next_s = RUN;
                    end
                end
                DONE: begin
                    if (accept_s) begin
                        time_next_s  = entry_s;
                        state_next_s = (entry_s != 16'h0000) ? ARMED : DONE;
                    end else begin
                        state_next_s = DONE;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                    ps_next_s    = PS_ZERO;
                    time_next_s  = 16'h0000;
                end
            endcase
        end
    end

    // State, prescaler, display and status registers; flags track the next state
    // so timer_done is high in the first cycle the display reads 00:00.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            ps_r       <= PS_ZERO;
            time_r     <= 16'h0000;
            running    <= 1'b0;
            timer_done <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            ps_r       <= ps_next_s;
            time_r     <= time_next_s;
            running    <= (state_next_s == RUN);
            timer_done <= (state_next_s == DONE);
        end
    end

    assign min_tens = time_r[15:12];
    assign min_ones = time_r[11:8];
    assign sec_tens = time_r[7:4];
    assign sec_ones = time_r[3:0];

endmodule
